mem_port_arbiter: RTL and testbench

- Sequencer/arbiter sharing one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (loads/stores driven by the decoded memread/memwrite controls).
- Issues one access at a time with a ready handshake and timeout.
- Returns registered read data.
- Generates stall_if/stall_mem so the pipeline freezes the losing or waiting stage.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified instruction/data memory between the IF
// stage (fetch) and the MEM stage (load/store). One access is in flight at a
// time. Read data and valid pulses are registered; the stall outputs are
// combinational so the pipeline freezes in the same cycle a request is waiting.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   if_req/if_addr           fetch request (held until if_valid) and PC
//   if_rdata/if_valid        fetched instruction, one-cycle completion pulse
//   d_memread/d_memwrite     load/store request (held until d_valid)
//   d_addr/d_wdata           load/store address and store data
//   d_rdata/d_valid          load data, one-cycle completion pulse
//   mem_en/mem_we            memory strobe / write enable, stable per access
//   mem_addr/mem_wdata       memory address / write data, stable per access
//   mem_rdata/mem_rdy        memory read data, valid when mem_rdy=1
//   stall_if/stall_mem       pipeline freeze requests
//   err                      sticky timeout flag, cleared only by rst
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_memread,
    input  logic          d_memwrite,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_s;
    logic [CW-1:0] wait_cnt_r;
    logic          data_live_s;
    logic          fetch_live_s;
    logic          busy_s;
    logic          timed_out_s;
    logic          done_s;

    // A request whose valid is high this cycle is being consumed, not pending.
    assign data_live_s  = (d_memread | d_memwrite) & ~d_valid;
    assign fetch_live_s = if_req & ~if_valid;

    assign busy_s      = (state_r == FETCH) || (state_r == DATA);
    assign timed_out_s = busy_s & ~mem_rdy & (wait_cnt_r == LAST_WAIT);
    assign done_s      = busy_s & (mem_rdy | timed_out_s);

    // IF must also hold while MEM waits so instruction order is preserved.
    assign stall_mem = data_live_s;
    assign stall_if  = fetch_live_s | data_live_s;

    // Grant selection; only consulted in IDLE or on the completion cycle.
    always_comb begin
        next_s = IDLE;
        case (state_r)
            IDLE, FETCH: begin
                if (data_live_s) begin
                    next_s = DATA;
                end else if (fetch_live_s) begin
                    next_s = FETCH;
                end else begin
                    next_s = IDLE;
                end
            end
            DATA: begin
                // Fetch goes first after a data access so it cannot starve.
                if (fetch_live_s) begin
                    next_s = FETCH;
                end else if (data_live_s) begin
                    next_s = DATA;
                end else begin
                    next_s = IDLE;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // Access sequencer: state, memory-side registers, read data and valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            wait_cnt_r <= {CW{1'b0}};
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            mem_wdata  <= {DW{1'b0}};
            if_rdata   <= {DW{1'b0}};
            d_rdata    <= {DW{1'b0}};
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            if (done_s) begin
                // A forced completion returns zero instead of bus data.
                if (state_r == FETCH) begin
                    if_rdata <= mem_rdy ? mem_rdata : {DW{1'b0}};
                    if_valid <= 1'b1;
                end else begin
                    if (!mem_we) begin
                        d_rdata <= mem_rdy ? mem_rdata : {DW{1'b0}};
                    end
                    d_valid <= 1'b1;
                end
                if (timed_out_s) begin
                    err <= 1'b1;
                end
            end

            if ((state_r == IDLE) || done_s) begin
                wait_cnt_r <= {CW{1'b0}};
                case (next_s)
                    DATA: begin
                        state_r   <= DATA;
                        mem_en    <= 1'b1;
                        mem_we    <= d_memwrite;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                    FETCH: begin
                        state_r  <= FETCH;
                        mem_en   <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                    end
                    default: begin
                        state_r <= IDLE;
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                endcase
            end else begin
                wait_cnt_r <= wait_cnt_r + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_memread;
    logic          d_memwrite;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_rdy;
    logic          stall_if;
    logic          stall_mem;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_delay = 0;   // -1: memory never answers

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_memread(d_memread), .d_memwrite(d_memwrite), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_kind: 0 no access, 1 fetch in flight, 2 data access in flight
    int            m_kind;
    int            m_age;
    logic          m_en, m_we, m_if_valid, m_d_valid, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;

    task automatic model_reset();
        m_kind = 0; m_age = 0;
        m_en = 1'b0; m_we = 1'b0; m_if_valid = 1'b0; m_d_valid = 1'b0; m_err = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    endtask

    task automatic model_step();
        bit            live_d, live_f, fin;
        int            nxt;
        logic [DW-1:0] val;
        if (rst) begin
            model_reset();
            return;
        end
        live_d = (d_memread || d_memwrite) && !m_d_valid;
        live_f = if_req && !m_if_valid;
        fin    = (m_kind != 0) && (mem_rdy || (m_age == TIMEOUT - 1));
        m_if_valid = 1'b0;
        m_d_valid  = 1'b0;
        if (fin) begin
            val = mem_rdy ? mem_rdata : '0;
            if (!mem_rdy) m_err = 1'b1;
            if (m_kind == 1) begin
                m_if_rdata = val;
                m_if_valid = 1'b1;
            end else begin
                m_d_valid = 1'b1;
                if (!m_we) m_d_rdata = val;
            end
        end
        if (m_kind == 0 || fin) begin
            if (m_kind == 2 && live_f) nxt = 1;
            else if (live_d)           nxt = 2;
            else if (live_f)           nxt = 1;
            else                       nxt = 0;
            if (nxt == 2) begin
                m_en = 1'b1; m_we = d_memwrite; m_addr = d_addr; m_wdata = d_wdata;
            end else if (nxt == 1) begin
                m_en = 1'b1; m_we = 1'b0; m_addr = if_addr;
            end else begin
                m_en = 1'b0; m_we = 1'b0;
            end
            m_kind = nxt;
            m_age  = 0;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        logic e_stall_mem, e_stall_if;
        forever begin
            @(negedge clk);
            e_stall_mem = (d_memread | d_memwrite) & ~m_d_valid;
            e_stall_if  = (if_req & ~m_if_valid) | e_stall_mem;
            check("cyc_mem_en",    mem_en,    m_en);
            check("cyc_mem_we",    mem_we,    m_we);
            check("cyc_mem_addr",  mem_addr,  m_addr);
            check("cyc_mem_wdata", mem_wdata, m_wdata);
            check("cyc_if_valid",  if_valid,  m_if_valid);
            check("cyc_if_rdata",  if_rdata,  m_if_rdata);
            check("cyc_d_valid",   d_valid,   m_d_valid);
            check("cyc_d_rdata",   d_rdata,   m_d_rdata);
            check("cyc_err",       err,       m_err);
            check("cyc_stall_mem", stall_mem, e_stall_mem);
            check("cyc_stall_if",  stall_if,  e_stall_if);
        end
    end

    // Memory responder: answers rdy_delay cycles into each access.
    initial begin
        int cnt;
        cnt = 0;
        mem_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_en) begin
                cnt = 0;
                mem_rdy = 1'b0;
            end else begin
                if (mem_rdy) cnt = 0;
                mem_rdy = (rdy_delay >= 0) && (cnt == rdy_delay);
                cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int if_cnt, d_cnt, if_since, d_since, if_gap, d_gap;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_memread = 1'b0; d_memwrite = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_en",   mem_en,   1'b0);
        check("rst_err",      err,      1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Fetch only
        if_req = 1'b1; if_addr = 32'h0000_0100; mem_rdata = 32'h0050_0093; rdy_delay = 0;
        @(negedge clk);
        check("fetch_en_before_edge", mem_en, 1'b0);
        check("fetch_stall_if_req",   stall_if, 1'b1);
        tick();
        @(negedge clk);
        check("fetch_en_rise",    mem_en,   1'b1);
        check("fetch_addr",       mem_addr, 32'h0000_0100);
        check("fetch_not_valid",  if_valid, 1'b0);
        tick();
        @(negedge clk);
        check("fetch_valid",      if_valid, 1'b1);
        check("fetch_rdata",      if_rdata, 32'h0050_0093);
        check("fetch_stall_done", stall_if, 1'b0);
        repeat (6) tick();
        if_req = 1'b0;
        repeat (4) tick();

        // Simultaneous load and fetch: data first, then fetch
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_memread = 1'b1; d_addr = 32'h0000_0040; mem_rdata = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        check("sim_data_addr", mem_addr,  32'h0000_0040);
        check("sim_data_we",   mem_we,    1'b0);
        check("sim_stall_if",  stall_if,  1'b1);
        check("sim_stall_mem", stall_mem, 1'b1);
        tick();
        @(negedge clk);
        check("sim_d_valid",     d_valid,   1'b1);
        check("sim_d_rdata",     d_rdata,   32'hDEAD_BEEF);
        check("sim_fetch_addr",  mem_addr,  32'h0000_0200);
        check("sim_stall_if2",   stall_if,  1'b1);
        check("sim_stall_mem2",  stall_mem, 1'b0);
        tick();
        d_memread = 1'b0;
        @(negedge clk);
        check("sim_if_valid", if_valid, 1'b1);
        check("sim_if_rdata", if_rdata, 32'hDEAD_BEEF);
        tick();
        if_req = 1'b0;
        repeat (4) tick();

        // Store with memory answering in the fourth access cycle
        d_memwrite = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'h1234_5678;
        mem_rdata = 32'hCAFE_F00D; rdy_delay = 3;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("st_en",    mem_en,    1'b1);
            check("st_we",    mem_we,    1'b1);
            check("st_addr",  mem_addr,  32'h0000_0080);
            check("st_wdata", mem_wdata, 32'h1234_5678);
            check("st_no_valid", d_valid, 1'b0);
        end
        tick();
        @(negedge clk);
        check("st_valid",     d_valid, 1'b1);
        check("st_rdata_kept", d_rdata, 32'hDEAD_BEEF);
        tick();
        d_memwrite = 1'b0;
        repeat (8) tick();

        // Timeout: memory never answers
        d_memread = 1'b1; d_addr = 32'h0000_0044; rdy_delay = -1;
        repeat (16) tick();
        @(negedge clk);
        check("to_not_yet",   d_valid, 1'b0);
        check("to_err_clear", err,     1'b0);
        tick();
        @(negedge clk);
        check("to_valid", d_valid, 1'b1);
        check("to_rdata", d_rdata, 32'h0);
        check("to_err",   err,     1'b1);
        tick();
        d_memread = 1'b0;
        repeat (18) tick();
        if_req = 1'b1; if_addr = 32'h0000_0104; mem_rdata = 32'h00A0_0113; rdy_delay = 0;
        repeat (2) tick();
        @(negedge clk);
        check("to_fetch_valid", if_valid, 1'b1);
        check("to_fetch_rdata", if_rdata, 32'h00A0_0113);
        check("to_err_sticky",  err,      1'b1);
        tick();
        if_req = 1'b0;
        repeat (3) tick();

        // Reset in the middle of a data access
        d_memread = 1'b1; d_addr = 32'h0000_0048; rdy_delay = -1;
        repeat (2) tick();
        @(negedge clk);
        check("rm_en_before", mem_en, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        d_memread = 1'b0;
        @(negedge clk);
        check("rm_en_drop",  mem_en,   1'b0);
        check("rm_err_drop", err,      1'b0);
        check("rm_d_valid",  d_valid,  1'b0);
        check("rm_addr",     mem_addr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0300; mem_rdata = 32'h1111_1111; rdy_delay = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rm_fetch_valid", if_valid, 1'b1);
        check("rm_fetch_rdata", if_rdata, 32'h1111_1111);
        tick();
        if_req = 1'b0;
        repeat (3) tick();

        // Alternation with both requesters always pending
        if_req = 1'b1; if_addr = 32'h0000_0400;
        d_memread = 1'b1; d_addr = 32'h0000_0050; mem_rdata = 32'h0BAD_F00D; rdy_delay = 1;
        if_cnt = 0; d_cnt = 0; if_since = 0; d_since = 0; if_gap = 0; d_gap = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            @(negedge clk);
            if (if_valid) begin
                if_cnt++;
                if (if_since > if_gap) if_gap = if_since;
                if_since = 0;
            end else begin
                if_since++;
            end
            if (d_valid) begin
                d_cnt++;
                if (d_since > d_gap) d_gap = d_since;
                d_since = 0;
            end else begin
                d_since++;
            end
        end
        check("alt_if_count", if_cnt, 5);
        check("alt_d_count",  d_cnt,  6);
        check("alt_if_gap",   if_gap, 4);
        check("alt_d_gap",    d_gap,  3);
        tick();
        if_req = 1'b0; d_memread = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
